// File: rtl/lsu_ctrl.sv
// lsu_ctrl - MEM-stage load/store controller, initiator side of the
// word-addressed, byte-masked data memory.
//
// Turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW byte-addressed requests into
// word-index + byte-mask accesses and returns aligned, sign/zero-extended
// load data. Illegal funct3 and (in the default build) misaligned accesses
// are reported as faults with the offending byte address.
//
// Build option:
//   LSU_MISALIGNED_SPLIT_EN  defined   : misaligned accesses are performed;
//                                        word-crossing ones take ACC0+ACC1.
//                            undefined : misaligned half/word accesses fault,
//                                        ACC1 is unreachable.
//
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   req_valid_i/ready_o request handshake (ready only in IDLE)
//   req_we_i            1 = store, 0 = load
//   req_funct3_i        RISC-V funct3 (size / sign)
//   req_addr_i          byte address
//   req_wdata_i         right-justified store data
//   rsp_valid_o         one-cycle response pulse
//   rsp_rdata_o         load result (0 for stores and faults)
//   rsp_err_o           access faulted
//   rsp_badaddr_o       faulting byte address (0 when no fault)
//   mem_we_o            memory write enable
//   mem_mask_o          byte enables
//   mem_addr_o          word index
//   mem_wdata_o         lane-aligned write data
//   mem_rdata_i         combinational read data for mem_addr_o
//
// State | meaning
// IDLE  | waiting for a request, req_ready_o = 1
// ACC0  | access to base word w, captures low read word
// ACC1  | access to word w+1 (word-crossing split only)
// RESP  | rsp_valid_o pulse, registered response on the outputs

module lsu_ctrl #(
    parameter int DW             = 32,
    parameter int MEM_SIZE_IN_KB = 1,
    localparam int ADDRW         = $clog2(MEM_SIZE_IN_KB * 256)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [31:0]      req_addr_i,
    input  logic [DW-1:0]    req_wdata_i,
    output logic             rsp_valid_o,
    output logic [DW-1:0]    rsp_rdata_o,
    output logic             rsp_err_o,
    output logic [31:0]      rsp_badaddr_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_mask_o,
    output logic [ADDRW-1:0] mem_addr_o,
    output logic [DW-1:0]    mem_wdata_o,
    input  logic [DW-1:0]    mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic             we_q;
    logic [2:0]       f3_q;
    logic [ADDRW+1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      lo_q;

    // ---------------------------------------------------------------
    // Request decode (on the live request, used at accept time)
    // ---------------------------------------------------------------
    logic req_illegal;
    logic req_fault;

    assign req_illegal = req_we_i
                       ? (req_funct3_i[2] || (req_funct3_i[1:0] == 2'b11))
                       : ((req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11));

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign req_fault = req_illegal;
`else
    logic req_misal;
    assign req_misal = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
                    || ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    assign req_fault = req_illegal || req_misal;
`endif

    // ---------------------------------------------------------------
    // Lane steering for the registered request
    // ---------------------------------------------------------------
    logic [1:0]       off;
    logic [ADDRW-1:0] w_base;
    logic [ADDRW-1:0] w_next;
    logic [3:0]       size_mask;
    logic [7:0]       m8;
    logic [63:0]      d64;

    assign off    = addr_q[1:0];
    assign w_base = addr_q[ADDRW+1:2];
    assign w_next = w_base + ADDRW'(1);   // wraps modulo 2^ADDRW

    always_comb begin
        size_mask = 4'b1111;
        case (f3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    assign m8  = {4'b0000, size_mask} << off;
    assign d64 = {32'h0, wdata_q} << {off, 3'b000};

    // ---------------------------------------------------------------
    // Load alignment and extension. In ACC0 the high word is zero (no
    // second access); in ACC1 the low word was captured in ACC0.
    // ---------------------------------------------------------------
    logic [31:0] ld_lo;
    logic [31:0] ld_hi;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;

    assign ld_lo    = (state == ACC1) ? lo_q : mem_rdata_i;
    assign ld_hi    = (state == ACC1) ? mem_rdata_i : 32'h0;
    assign ld_shift = 32'({ld_hi, ld_lo} >> {off, 3'b000});

    always_comb begin
        ld_ext = ld_shift;
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}},  ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        mem_we_o    = 1'b0;
        mem_mask_o  = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_nxt = req_fault ? RESP : ACC0;
            end
            ACC0: begin
                mem_we_o    = we_q;
                mem_mask_o  = m8[3:0];
                mem_addr_o  = w_base;
                mem_wdata_o = d64[31:0];
`ifdef LSU_MISALIGNED_SPLIT_EN
                state_nxt   = (m8[7:4] != 4'b0000) ? ACC1 : RESP;
`else
                state_nxt   = RESP;
`endif
            end
            ACC1: begin
                mem_we_o    = we_q;
                mem_mask_o  = m8[7:4];
                mem_addr_o  = w_next;
                mem_wdata_o = d64[63:32];
                state_nxt   = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Request capture and low-word capture
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            lo_q    <= 32'h0;
        end else begin
            if (state == IDLE && req_valid_i) begin
                we_q    <= req_we_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i[ADDRW+1:0];
                wdata_q <= req_wdata_i;
            end
            if (state == ACC0) lo_q <= mem_rdata_i;
        end
    end

    // ---------------------------------------------------------------
    // Response registers: written only on entry to RESP so they hold
    // until the next response.
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_badaddr_o <= 32'h0;
        end else if (state == IDLE && req_valid_i && req_fault) begin
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_badaddr_o <= req_addr_i;
        end else if ((state == ACC0 || state == ACC1) && state_nxt == RESP) begin
            rsp_rdata_o   <= we_q ? 32'h0 : ld_ext;
            rsp_err_o     <= 1'b0;
            rsp_badaddr_o <= 32'h0;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: table of directed load/store vectors against a
// behavioural byte-masked memory, plus hand sequences for access lane
// steering, split/fault handling, address wrap and reset abort.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] rsp_badaddr;
    logic        mem_we;
    logic [3:0]  mem_mask;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_ctrl #(.DW(32), .MEM_SIZE_IN_KB(1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_badaddr_o(rsp_badaddr),
        .mem_we_o     (mem_we),
        .mem_mask_o   (mem_mask),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory
    logic [31:0] mem [256];
    logic        tb_init;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Results of the most recent request
    int          r_lat, r_acc, r_wen;
    logic [31:0] r_rd, r_ba, r_post_rd;
    logic        r_err, r_post_valid;
    logic [7:0]  a_addr [2];
    logic [3:0]  a_mask [2];
    logic [31:0] a_wd   [2];
    logic        a_we   [2];

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        int g;
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("req_ready", {31'h0, req_ready}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            a_addr[k] = 8'h0; a_mask[k] = 4'h0; a_wd[k] = 32'h0; a_we[k] = 1'b0;
        end
        r_lat = 0; r_acc = 0; r_wen = 0; r_rd = 32'hx; r_err = 1'bx; r_ba = 32'hx;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (mem_mask != 4'h0) begin
                if (r_acc < 2) begin
                    a_addr[r_acc] = mem_addr; a_mask[r_acc] = mem_mask;
                    a_wd[r_acc] = mem_wdata;  a_we[r_acc] = mem_we;
                end
                r_acc++;
            end
            if (mem_we) r_wen++;
            if (rsp_valid) begin
                r_lat = n; r_rd = rsp_rdata; r_err = rsp_err; r_ba = rsp_badaddr;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        r_post_valid = rsp_valid;
        r_post_rd    = rsp_rdata;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [31:0] ba;
        int          lat;
    } vec_t;

    vec_t vq[$];
    int   nv;
    logic [31:0] saved_w;

    initial begin
        // ---------------- table (word2 = DEADBEEF written by hand seq A) ----
        vq.push_back('{1'b1, 3'b010, 32'h0000000C, 32'h11223344, 32'h0, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b010, 32'h00000008, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b000, 32'h0000000B, 32'h0, 32'hFFFFFFDE, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b100, 32'h0000000B, 32'h0, 32'h000000DE, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b101, 32'h0000000A, 32'h0, 32'h0000DEAD, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b001, 32'h00000008, 32'h0, 32'hFFFFBEEF, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b100, 32'h0000000C, 32'h0, 32'h00000044, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b010, 32'hFFFF0008, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b011, 32'h00000008, 32'h0, 32'h0, 1'b1, 32'h00000008, 1});
        vq.push_back('{1'b1, 3'b100, 32'h00000010, 32'h99, 32'h0, 1'b1, 32'h00000010, 1});
        vq.push_back('{1'b0, 3'b111, 32'h00000004, 32'h0, 32'h0, 1'b1, 32'h00000004, 1});
        vq.push_back('{1'b1, 3'b000, 32'h00000011, 32'hAB, 32'h0, 1'b0, 32'h0, 2});
        vq.push_back('{1'b1, 3'b001, 32'h00000012, 32'h5678, 32'h0, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b010, 32'h00000010, 32'h0, 32'h5678AB00, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b001, 32'h00000010, 32'h0, 32'hFFFFAB00, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b001, 32'h00000012, 32'h0, 32'h00005678, 1'b0, 32'h0, 2});
        vq.push_back('{1'b0, 3'b010, 32'h00000009, 32'h0,
                       SPLIT ? 32'h44DEADBE : 32'h0, !SPLIT, SPLIT ? 32'h0 : 32'h9, SPLIT ? 3 : 1});
        vq.push_back('{1'b0, 3'b001, 32'h00000009, 32'h0,
                       SPLIT ? 32'hFFFFADBE : 32'h0, !SPLIT, SPLIT ? 32'h0 : 32'h9, SPLIT ? 2 : 1});
        vq.push_back('{1'b0, 3'b101, 32'h0000000B, 32'h0,
                       SPLIT ? 32'h000044DE : 32'h0, !SPLIT, SPLIT ? 32'h0 : 32'hB, SPLIT ? 3 : 1});
        vq.push_back('{1'b1, 3'b010, 32'h000003FC, 32'hAABBCCDD, 32'h0, 1'b0, 32'h0, 2});
        vq.push_back('{1'b1, 3'b010, 32'h00000000, 32'h00000011, 32'h0, 1'b0, 32'h0, 2});

        // ---------------- reset ----------------
        rst = 1'b1; tb_init = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
        #1;
        chk("rst_ready",   {31'h0, req_ready}, 32'h1);
        chk("rst_valid",   {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp",     {rsp_rdata[30:0], rsp_err} ^ rsp_badaddr, 32'h0);
        chk("rst_mem",     {mem_we, mem_mask, mem_addr} | mem_wdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; tb_init = 1'b0; req_valid = 1'b0;
        chk("rst_no_write", mem[8], 32'h0);

        // ---------------- hand A: SW 0x8 lane drive ----------------
        do_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
        chk("swA_addr", {24'h0, a_addr[0]}, 32'h2);
        chk("swA_mask", {28'h0, a_mask[0]}, 32'hF);
        chk("swA_wd",   a_wd[0], 32'hDEADBEEF);
        chk("swA_we",   {31'h0, a_we[0]}, 32'h1);
        chk("swA_lat",  r_lat, 2);
        chk("swA_err",  {31'h0, r_err}, 32'h0);

        // ---------------- table loop ----------------
        for (int i = 0; i < vq.size(); i++) begin
            do_req(vq[i].we, vq[i].f3, vq[i].addr, vq[i].wd);
            chk($sformatf("v%0d_lat", i),   r_lat, vq[i].lat);
            chk($sformatf("v%0d_rdata", i), r_rd, vq[i].rd);
            chk($sformatf("v%0d_err", i),   {31'h0, r_err}, {31'h0, vq[i].err});
            chk($sformatf("v%0d_bad", i),   r_ba, vq[i].ba);
            chk($sformatf("v%0d_acc", i),   r_acc, vq[i].err ? 0 : vq[i].lat - 1);
            chk($sformatf("v%0d_wen", i),   r_wen, (vq[i].we && !vq[i].err) ? vq[i].lat - 1 : 0);
            chk($sformatf("v%0d_pulse", i), {31'h0, r_post_valid}, 32'h0);
            chk($sformatf("v%0d_hold", i),  r_post_rd, vq[i].rd);
        end

        // ---------------- hand B: wrap LW at last word + 1 ----------------
        do_req(1'b0, 3'b010, 32'h000003FD, 32'h0);
        chk("wrap_rdata", r_rd, SPLIT ? 32'h11AABBCC : 32'h0);
        chk("wrap_err",   {31'h0, r_err}, {31'h0, !SPLIT});
        chk("wrap_a0",    {24'h0, a_addr[0]}, SPLIT ? 32'hFF : 32'h0);
        chk("wrap_a1",    {24'h0, a_addr[1]}, 32'h0);
        chk("wrap_m1",    {28'h0, a_mask[1]}, SPLIT ? 32'h1 : 32'h0);
        chk("wrap_lat",   r_lat, SPLIT ? 3 : 1);

        // ---------------- hand C: SH 0x7 across a word boundary ----------------
        do_req(1'b1, 3'b001, 32'h7, 32'h1234);
        chk("sh7_lat",  r_lat, SPLIT ? 3 : 1);
        chk("sh7_err",  {31'h0, r_err}, {31'h0, !SPLIT});
        chk("sh7_bad",  r_ba, SPLIT ? 32'h0 : 32'h7);
        chk("sh7_wen",  r_wen, SPLIT ? 2 : 0);
        chk("sh7_a0",   {24'h0, a_addr[0]}, SPLIT ? 32'h1 : 32'h0);
        chk("sh7_m0",   {28'h0, a_mask[0]}, SPLIT ? 32'h8 : 32'h0);
        chk("sh7_d0",   a_wd[0], SPLIT ? 32'h34000000 : 32'h0);
        chk("sh7_a1",   {24'h0, a_addr[1]}, SPLIT ? 32'h2 : 32'h0);
        chk("sh7_m1",   {28'h0, a_mask[1]}, SPLIT ? 32'h1 : 32'h0);
        chk("sh7_d1",   a_wd[1], SPLIT ? 32'h00000012 : 32'h0);
        chk("sh7_mem2", mem[2], SPLIT ? 32'hDEADBE12 : 32'hDEADBEEF);

        // ---------------- hand D: reset during the last access ----------------
        @(negedge clk);
        saved_w = SPLIT ? mem[2] : mem[8];
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = SPLIT ? 3'b001 : 3'b010;
        req_addr = SPLIT ? 32'h7 : 32'h20; req_wdata = SPLIT ? 32'hABCD : 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (SPLIT ? 1 : 0) @(negedge clk);
        chk("rstD_busy", {28'h0, mem_mask}, SPLIT ? 32'h1 : 32'hF);
        rst = 1'b1;
        #1;
        chk("rstD_ready", {31'h0, req_ready}, 32'h1);
        chk("rstD_err",   {31'h0, rsp_err}, 32'h0);
        chk("rstD_bad",   rsp_badaddr, 32'h0);
        chk("rstD_mem",   {mem_we, mem_mask, mem_addr} | mem_wdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) nv++;
            @(negedge clk);
        end
        chk("rstD_nopulse", nv, 0);
        chk("rstD_word",    SPLIT ? mem[2] : mem[8], saved_w);
        chk("rstD_first",   {24'h0, mem[1][31:24]}, SPLIT ? 32'hCD : 32'h0);
        do_req(1'b0, 3'b010, 32'h8, 32'h0);
        chk("rstD_after",   r_rd, SPLIT ? 32'hDEADBE12 : 32'hDEADBEEF);
        chk("rstD_alat",    r_lat, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
